// File: rtl/rom_pkg.sv
// Shared constants for the ROM streaming master: FSM state encodings and FIFO depth.
package rom_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/sync_fifo2.sv
// Two-entry first-word-fall-through FIFO; head entry drives dout directly.
module sync_fifo2
    import rom_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [1:0]       occ;

    assign dout  = head;
    assign count = occ;
    assign empty = (occ == 2'd0);
    assign full  = (occ == 2'(FIFO_DEPTH));

    // Storage and occupancy update; flush empties the FIFO like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            assert (!(push && !pop && full));
            assert (!(pop && empty));
            unique case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= din;
                    else             tail <= din;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged: either replace the lone head or shift and refill.
                    if (occ == 2'd2) begin
                        head <= tail;
                        tail <= din;
                    end else begin
                        head <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rom_streamer.sv
// Read-side master for a synchronous program ROM: walks a window of words and
// presents them as a bubble-free valid/ready stream through a 2-entry FIFO.
module rom_streamer
    import rom_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  loop,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [WIDTH-1:0]      rom_q,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] next_addr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [ADDR_WIDTH:0]   remaining;
    logic [ADDR_WIDTH:0]   count_reg;
    logic [ADDR_WIDTH-1:0] base_reg;
    logic                  loop_reg;
    logic                  rd_pend;

    logic [1:0]            fifo_count;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  credit_ok;
    logic                  issue;
    logic                  drain_done;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid & out_ready;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // At most two words may be stored or in flight once this cycle's pop is accounted for.
    assign credit_ok = ({1'b0, fifo_count} + {2'b00, rd_pend}) <= (3'd1 + {2'b00, pop});
    assign issue     = (state == ST_RUN) && (remaining != '0) && credit_ok && !stop;

    // The issued address is presented combinationally so the registered ROM returns
    // its word while rd_pend is high; addr_hold keeps the last address between issues.
    assign rom_addr  = issue ? next_addr : addr_hold;

    // The FIFO will be empty after this edge with nothing left in flight.
    assign drain_done = !rd_pend && ((fifo_count == 2'd0) || (fifo_count == 2'd1 && pop));

    sync_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (stop),
        .push  (rd_pend),
        .pop   (pop),
        .din   (rom_q),
        .dout  (out_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // FSM, address/remaining counters and read-pending tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            next_addr <= '0;
            addr_hold <= '0;
            remaining <= '0;
            count_reg <= '0;
            base_reg  <= '0;
            loop_reg  <= 1'b0;
            rd_pend   <= 1'b0;
        end else if (stop) begin
            state     <= ST_IDLE;
            remaining <= '0;
            rd_pend   <= 1'b0;
        end else begin
            assert (!(rd_pend && fifo_full && !pop));
            rd_pend <= issue;
            if (issue) addr_hold <= next_addr;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base_reg  <= base_addr;
                        count_reg <= count;
                        loop_reg  <= loop;
                        next_addr <= base_addr;
                        remaining <= count;
                        state     <= (count == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        if (remaining == (ADDR_WIDTH+1)'(1)) begin
                            if (loop_reg) begin
                                remaining <= count_reg;
                                next_addr <= base_reg;
                            end else begin
                                remaining <= '0;
                                next_addr <= next_addr + ADDR_WIDTH'(1);
                                state     <= ST_DRAIN;
                            end
                        end else begin
                            remaining <= remaining - (ADDR_WIDTH+1)'(1);
                            next_addr <= next_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) state <= ST_DONE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_streamer.sv
// Self-checking bench for rom_streamer: table-driven windows with a scoreboard
// queue, plus hand-written loop/stop and reset-mid-transfer sequences.
module tb_rom_streamer;

    logic        clk = 1'b0;
    logic        rst, start, stop, loop;
    logic [2:0]  base_addr;
    logic [3:0]  count;
    logic [2:0]  rom_addr;
    logic [31:0] rom_q;
    logic [31:0] out_data;
    logic        out_valid, out_ready, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [8];
    logic [31:0] exp_q [$];

    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          last_pop_cyc = -1;
    int          xfer_cnt = 0;
    logic [31:0] last_data = '0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;

    int   ready_mode   = 0;
    logic manual_ready = 1'b1;

    typedef struct {
        logic [2:0]  b;
        logic [3:0]  c;
        int          mode;
        bit          second;
        bit          lat;
        int          exp_words;
        logic [31:0] exp_last;
    } vec_t;

    always #5 clk = ~clk;

    // Registered ROM model, one-cycle read latency.
    always @(posedge clk) rom_q <= mem[rom_addr];

    rom_streamer #(
        .ADDR_WIDTH (3),
        .WIDTH      (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .loop      (loop),
        .base_addr (base_addr),
        .count     (count),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Consumer ready driver: 0 = always ready, 1 = random, 2 = manual.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = manual_ready;
            endcase
        end
    end

    // Stream monitor: scoreboard pops, stall stability, done tracking.
    always @(negedge clk) begin
        cyc++;
        if (stall_prev) begin
            check_bit("stall_valid", out_valid, 1'b1);
            check_word("stall_data", out_data, stall_data);
        end
        stall_prev = out_valid && !out_ready && !rst && !stop;
        stall_data = out_data;
        if (out_valid && out_ready && !rst && !stop) begin
            xfer_cnt++;
            last_data = out_data;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL extra_word: got %h expected no transfer", out_data);
            end else begin
                check_word("stream_data", out_data, exp_q.pop_front());
                if (exp_q.size() == 0) last_pop_cyc = cyc;
            end
        end
        if (done) begin
            done_cnt++;
            if (done_cnt == 1) done_cyc = cyc;
        end
    end

    task automatic run_window(input vec_t v);
        int t0;
        int waited;
        ready_mode   = v.mode;
        done_cnt     = 0;
        done_cyc     = -1;
        last_pop_cyc = -1;
        xfer_cnt     = 0;
        last_data    = '0;
        for (int i = 0; i < int'(v.c); i++)
            exp_q.push_back(32'hA000_0000 + 32'((int'(v.b) + i) % 8));
        @(posedge clk); #1;
        base_addr = v.b; count = v.c; loop = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; t0 = cyc;
        base_addr = 3'd5; count = 4'd2;
        check_bit("busy_after_start", busy, 1'b1);
        if (v.lat) begin
            @(negedge clk); #1; check_bit("lat_c1_valid", out_valid, 1'b0);
            @(negedge clk); #1; check_bit("lat_c2_valid", out_valid, 1'b0);
            @(negedge clk); #1; check_bit("lat_c3_valid", out_valid, 1'b1);
            check_word("lat_c3_data", out_data, 32'hA000_0000 + 32'(v.b));
        end
        if (v.second) begin
            @(posedge clk); #1; start = 1'b1; loop = 1'b1;
            @(posedge clk); #1; start = 1'b0; loop = 1'b0;
        end
        waited = 0;
        while (done_cnt == 0 && waited < 200) begin
            @(negedge clk); #1;
            waited++;
        end
        check_bit("done_seen", done_cnt != 0, 1'b1);
        @(negedge clk); #1;
        check_bit("done_one_cycle", done, 1'b0);
        check_bit("busy_after_done", busy, 1'b0);
        check_bit("valid_after_done", out_valid, 1'b0);
        check_word("done_pulses", 32'(done_cnt), 32'd1);
        check_word("words_left", 32'(exp_q.size()), 32'd0);
        check_word("xfer_count", 32'(xfer_cnt), 32'(v.exp_words));
        check_word("last_word", last_data, v.exp_last);
        if (v.c == 4'd0) check_word("done_time_cnt0", 32'(done_cyc), 32'(t0 + 1));
        else             check_word("done_time", 32'(done_cyc), 32'(last_pop_cyc + 1));
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [8];
        int   waited;
        vecs[0] = '{b: 3'd2, c: 4'd4, mode: 0, second: 1'b0, lat: 1'b1, exp_words: 4, exp_last: 32'hA000_0005};
        vecs[1] = '{b: 3'd6, c: 4'd4, mode: 0, second: 1'b0, lat: 1'b0, exp_words: 4, exp_last: 32'hA000_0001};
        vecs[2] = '{b: 3'd0, c: 4'd8, mode: 1, second: 1'b0, lat: 1'b0, exp_words: 8, exp_last: 32'hA000_0007};
        vecs[3] = '{b: 3'd0, c: 4'd0, mode: 0, second: 1'b0, lat: 1'b0, exp_words: 0, exp_last: 32'h0000_0000};
        vecs[4] = '{b: 3'd2, c: 4'd4, mode: 0, second: 1'b1, lat: 1'b0, exp_words: 4, exp_last: 32'hA000_0005};
        vecs[5] = '{b: 3'd7, c: 4'd2, mode: 0, second: 1'b0, lat: 1'b0, exp_words: 2, exp_last: 32'hA000_0000};
        vecs[6] = '{b: 3'd5, c: 4'd1, mode: 1, second: 1'b0, lat: 1'b0, exp_words: 1, exp_last: 32'hA000_0005};
        vecs[7] = '{b: 3'd3, c: 4'd8, mode: 1, second: 1'b0, lat: 1'b0, exp_words: 8, exp_last: 32'hA000_0002};

        for (int i = 0; i < 8; i++) mem[i] = 32'hA000_0000 + 32'(i);
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        base_addr = '0; count = '0;
        repeat (2) @(posedge clk);
        #1;
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_valid", out_valid, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_word("rst_rom_addr", 32'(rom_addr), 32'd0);
        check_word("rst_out_data", out_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_window(vecs[i]);

        // Loop mode: pattern 1,2,3 repeating, then stop.
        ready_mode = 0; done_cnt = 0;
        for (int i = 0; i < 20; i++) exp_q.push_back(32'hA000_0001 + 32'(i % 3));
        @(posedge clk); #1;
        base_addr = 3'd1; count = 4'd3; loop = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; loop = 1'b0;
        waited = 0;
        while (exp_q.size() > 10 && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        check_bit("loop_ten_words", exp_q.size() <= 10, 1'b1);
        @(posedge clk); #1; stop = 1'b1;
        @(posedge clk); #1; stop = 1'b0;
        check_bit("stop_valid", out_valid, 1'b0);
        check_bit("stop_busy", busy, 1'b0);
        exp_q.delete();
        @(negedge clk); #1;
        check_bit("stop_valid_later", out_valid, 1'b0);
        check_word("loop_no_done", 32'(done_cnt), 32'd0);

        // Reset with one word stored and one read pending.
        ready_mode = 2; manual_ready = 1'b0;
        @(posedge clk); #1;
        base_addr = 3'd3; count = 4'd4; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_bit("pre_rst_valid", out_valid, 1'b1);
        check_word("pre_rst_data", out_data, 32'hA000_0003);
        rst = 1'b1;
        @(posedge clk); #1;
        check_bit("midrst_valid", out_valid, 1'b0);
        check_bit("midrst_busy", busy, 1'b0);
        check_bit("midrst_done", done, 1'b0);
        check_word("midrst_rom_addr", 32'(rom_addr), 32'd0);
        check_word("midrst_out_data", out_data, 32'd0);
        rst = 1'b0;
        manual_ready = 1'b1;
        @(negedge clk); #1;
        check_bit("postrst_valid", out_valid, 1'b0);
        run_window('{b: 3'd3, c: 4'd4, mode: 0, second: 1'b0, lat: 1'b1, exp_words: 4, exp_last: 32'hA000_0006});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
